// File: rtl/interrupt_sequencer_if.sv
// CSR, board-input and fetch-redirect signals of the interrupt sequencer.
// The slave modport is the sequencer's view; master is the surrounding core/board.
interface interrupt_sequencer_if;
  logic        timer_interrupt_trigger_in;
  logic        csr_mie_mtie_in;
  logic        csr_mie_meie_in;
  logic [3:0]  csr_mbutton_ctrl_in;
  logic [3:0]  csr_mswitch_ctrl_in;
  logic [3:0]  button_in;
  logic [3:0]  switch_in;
  logic        stall_signal_in;
  logic        return_interrupt_signal_in;
  logic [63:0] csr_mepc_in;
  logic        interrupt_signal_out;
  logic        pc_redirect_out;
  logic [63:0] pc_target_out;
  logic [3:0]  int_cause_out;
  logic [2:0]  int_source_out;
  logic        in_handler_out;
  logic [8:0]  pending_out;

  modport slave (
    input  timer_interrupt_trigger_in, csr_mie_mtie_in, csr_mie_meie_in,
    input  csr_mbutton_ctrl_in, csr_mswitch_ctrl_in, button_in, switch_in,
    input  stall_signal_in, return_interrupt_signal_in, csr_mepc_in,
    output interrupt_signal_out, pc_redirect_out, pc_target_out,
    output int_cause_out, int_source_out, in_handler_out, pending_out
  );

  modport master (
    output timer_interrupt_trigger_in, csr_mie_mtie_in, csr_mie_meie_in,
    output csr_mbutton_ctrl_in, csr_mswitch_ctrl_in, button_in, switch_in,
    output stall_signal_in, return_interrupt_signal_in, csr_mepc_in,
    input  interrupt_signal_out, pc_redirect_out, pc_target_out,
    input  int_cause_out, int_source_out, in_handler_out, pending_out
  );
endinterface

// File: rtl/interrupt_sequencer.sv
// Arbitrates timer and button/switch interrupts into sticky pending bits and sequences trap entry/return.
// All outputs registered; entry/return pulses last one clk_in period.
module interrupt_sequencer #(
  parameter logic [63:0] MTVEC_ADDR  = 64'h100,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic                  clk_in,
  input logic                  rst_n_in,
  interrupt_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ENTER, HANDLER, RETURN} state_t;

  state_t                      state;
  logic [SYNC_STAGES-1:0][7:0] ext_sync;
  logic [7:0]                  ext_prev;
  logic [7:0]                  ext_now;
  logic [7:0]                  ext_edge;
  logic [7:0]                  ext_mask;
  logic                        timer_prev;
  logic [8:0]                  pending;
  logic [8:0]                  pend_set;
  logic [8:0]                  pend_clr;
  logic [8:0]                  eligible;
  logic [8:0]                  win_bit;
  logic                        win_vld;
  logic [3:0]                  win_cause;
  logic [2:0]                  win_src;
  logic                        take;
  logic                        irq_q;
  logic                        redirect_q;
  logic [63:0]                 target_q;
  logic [3:0]                  cause_q;
  logic [2:0]                  source_q;
  logic                        in_handler_q;

  // Buttons trigger on press only; switches on either flip.
  assign ext_now  = ext_sync[SYNC_STAGES-1];
  assign ext_edge = {ext_now[7:4] ^ ext_prev[7:4], ext_now[3:0] & ~ext_prev[3:0]};
  assign pend_set = {bus.timer_interrupt_trigger_in & ~timer_prev, ext_edge};
  assign ext_mask = {bus.csr_mswitch_ctrl_in, bus.csr_mbutton_ctrl_in};
  assign eligible = {pending[8] & bus.csr_mie_mtie_in,
                     pending[7:0] & ext_mask & {8{bus.csr_mie_meie_in}}};

  always_comb begin
    win_vld   = 1'b0;
    win_bit   = '0;
    win_cause = 4'd0;
    win_src   = 3'd0;
    if (eligible[8]) begin
      win_vld    = 1'b1;
      win_bit[8] = 1'b1;
      win_cause  = 4'd7;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (!win_vld && eligible[i]) begin
          win_vld    = 1'b1;
          win_bit[i] = 1'b1;
          win_cause  = 4'd11;
          win_src    = 3'(i);
        end
      end
    end
  end

  assign take     = (state == IDLE) && win_vld && !bus.stall_signal_in;
  assign pend_clr = take ? win_bit : '0;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      ext_sync   <= '0;
      ext_prev   <= '0;
      timer_prev <= 1'b0;
    end else begin
      ext_sync   <= {ext_sync[SYNC_STAGES-2:0], bus.switch_in, bus.button_in};
      ext_prev   <= ext_now;
      timer_prev <= bus.timer_interrupt_trigger_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state        <= IDLE;
      pending      <= '0;
      irq_q        <= 1'b0;
      redirect_q   <= 1'b0;
      target_q     <= '0;
      cause_q      <= '0;
      source_q     <= '0;
      in_handler_q <= 1'b0;
    end else begin
      irq_q      <= 1'b0;
      redirect_q <= 1'b0;
      // A new edge on the winning source in the same cycle keeps it pending.
      pending    <= (pending & ~pend_clr) | pend_set;
      case (state)
        IDLE: begin
          if (take) begin
            state        <= ENTER;
            irq_q        <= 1'b1;
            redirect_q   <= 1'b1;
            target_q     <= MTVEC_ADDR;
            cause_q      <= win_cause;
            source_q     <= win_src;
            in_handler_q <= 1'b1;
          end
        end
        ENTER: state <= HANDLER;
        HANDLER: begin
          if (bus.return_interrupt_signal_in && !bus.stall_signal_in) begin
            state        <= RETURN;
            redirect_q   <= 1'b1;
            target_q     <= bus.csr_mepc_in;
            in_handler_q <= 1'b0;
          end
        end
        RETURN:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.interrupt_signal_out = irq_q;
  assign bus.pc_redirect_out      = redirect_q;
  assign bus.pc_target_out        = target_q;
  assign bus.int_cause_out        = cause_q;
  assign bus.int_source_out       = source_q;
  assign bus.in_handler_out       = in_handler_q;
  assign bus.pending_out          = pending;
endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed scenarios plus random traffic against an event-level reference model of the sequencer.
module tb_interrupt_sequencer;
  localparam int          SYNC  = 2;
  localparam logic [63:0] MTVEC = 64'h100;

  logic clk_in = 1'b0;
  logic rst_n_in;
  int   n_checks = 0;
  int   n_fail   = 0;

  interrupt_sequencer_if bus();

  interrupt_sequencer #(.MTVEC_ADDR(MTVEC), .SYNC_STAGES(SYNC)) dut (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .bus     (bus.slave)
  );

  always #5 clk_in = ~clk_in;

  // Reference model state: raw board samples per edge, most recent first.
  logic [7:0]  m_hist[$];
  logic        m_trig_prev;
  logic [8:0]  m_pend;
  bit          m_inh, m_ent_last, m_ret_last, m_irq, m_redir;
  logic [63:0] m_target;
  logic [3:0]  m_cause;
  logic [2:0]  m_src;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hist = {};
    for (int i = 0; i <= SYNC; i++) m_hist.push_back(8'h00);
    m_trig_prev = 1'b0; m_pend = '0;
    m_inh = 0; m_ent_last = 0; m_ret_last = 0; m_irq = 0; m_redir = 0;
    m_target = '0; m_cause = '0; m_src = '0;
  endtask

  task automatic model_edge();
    logic [7:0] raw, syn, prv, ev, mask;
    logic [8:0] set, elig, clr;
    bit take, ret;
    int win;
    raw = {bus.switch_in, bus.button_in};
    if (!rst_n_in) begin
      model_reset();
      return;
    end
    syn = m_hist[SYNC-1];
    prv = m_hist[SYNC];
    for (int i = 0; i < 4; i++) ev[i] = syn[i] && !prv[i];
    for (int i = 4; i < 8; i++) ev[i] = syn[i] != prv[i];
    set  = {bus.timer_interrupt_trigger_in && !m_trig_prev, ev};
    mask = {bus.csr_mswitch_ctrl_in, bus.csr_mbutton_ctrl_in};
    elig[8] = m_pend[8] && bus.csr_mie_mtie_in;
    for (int i = 0; i < 8; i++) elig[i] = m_pend[i] && bus.csr_mie_meie_in && mask[i];
    win = -1;
    if (elig[8]) win = 8;
    else for (int i = 7; i >= 0; i--) if (elig[i]) win = i;
    take = !m_inh && !m_ret_last && (win >= 0) && !bus.stall_signal_in;
    ret  = m_inh && !m_ent_last && bus.return_interrupt_signal_in && !bus.stall_signal_in;
    clr  = take ? (9'd1 << win) : 9'd0;
    m_pend = (m_pend & ~clr) | set;
    if (take) begin
      m_cause  = (win == 8) ? 4'd7 : 4'd11;
      m_src    = (win == 8) ? 3'd0 : 3'(win);
      m_target = MTVEC;
      m_inh    = 1;
    end
    if (ret) begin
      m_target = bus.csr_mepc_in;
      m_inh    = 0;
    end
    m_irq = take; m_redir = take || ret;
    m_ent_last = take; m_ret_last = ret;
    m_trig_prev = bus.timer_interrupt_trigger_in;
    m_hist.push_front(raw);
    void'(m_hist.pop_back());
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
    model_edge();
    check_eq("irq",      bus.interrupt_signal_out, m_irq);
    check_eq("redirect", bus.pc_redirect_out, m_redir);
    check_eq("target",   bus.pc_target_out, m_target);
    check_eq("cause",    bus.int_cause_out, m_cause);
    check_eq("source",   bus.int_source_out, m_src);
    check_eq("in_hdl",   bus.in_handler_out, m_inh);
    check_eq("pending",  bus.pending_out, m_pend);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_irq(input string tag, input int budget, input int exp_cycles);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.interrupt_signal_out && n < budget);
    check_eq(tag, n, exp_cycles);
  endtask

  task automatic finish_handler();
    bus.return_interrupt_signal_in = 1'b1;
    run(3);
    bus.return_interrupt_signal_in = 1'b0;
    run(2);
  endtask

  task automatic pulse_timer();
    bus.timer_interrupt_trigger_in = 1'b1;
    step();
    bus.timer_interrupt_trigger_in = 1'b0;
  endtask

  initial begin
    model_reset();
    rst_n_in = 1'b0;
    bus.timer_interrupt_trigger_in = 0; bus.csr_mie_mtie_in = 0; bus.csr_mie_meie_in = 0;
    bus.csr_mbutton_ctrl_in = 0; bus.csr_mswitch_ctrl_in = 0; bus.button_in = 0;
    bus.switch_in = 0; bus.stall_signal_in = 0; bus.return_interrupt_signal_in = 0;
    bus.csr_mepc_in = 64'h0;
    run(2);
    check_eq("rst_irq", bus.interrupt_signal_out, 0);
    check_eq("rst_pend", bus.pending_out, 0);
    rst_n_in = 1'b1;
    run(2);

    // Timer entry one cycle after pending.
    bus.csr_mie_mtie_in = 1'b1;
    pulse_timer();
    check_eq("t1_pend", bus.pending_out[8], 1);
    check_eq("t1_noirq", bus.interrupt_signal_out, 0);
    step();
    check_eq("t1_irq", bus.interrupt_signal_out, 1);
    check_eq("t1_target", bus.pc_target_out, 64'h100);
    check_eq("t1_cause", bus.int_cause_out, 7);
    check_eq("t1_src", bus.int_source_out, 0);
    bus.csr_mepc_in = 64'h500;
    finish_handler();

    // Button 2: entry at the fourth edge after the press.
    bus.csr_mie_meie_in = 1'b1;
    bus.csr_mbutton_ctrl_in = 4'b0100;
    bus.button_in = 4'b0100;
    wait_irq("t2_lat", 8, 4);
    check_eq("t2_cause", bus.int_cause_out, 11);
    check_eq("t2_src", bus.int_source_out, 2);
    check_eq("t2_pend", bus.pending_out[2], 0);
    bus.button_in = 4'b0000;
    finish_handler();

    // Timer beats button 0; button 0 re-enters two cycles after the return.
    bus.csr_mbutton_ctrl_in = 4'b0001;
    bus.stall_signal_in = 1'b1;
    bus.button_in = 4'b0001;
    pulse_timer();
    run(5);
    bus.stall_signal_in = 1'b0;
    step();
    check_eq("t3_irq", bus.interrupt_signal_out, 1);
    check_eq("t3_cause", bus.int_cause_out, 7);
    bus.csr_mepc_in = 64'h2040;
    bus.return_interrupt_signal_in = 1'b1;
    run(2);
    check_eq("t3_ret_redir", bus.pc_redirect_out, 1);
    check_eq("t3_ret_target", bus.pc_target_out, 64'h2040);
    bus.return_interrupt_signal_in = 1'b0;
    step();
    check_eq("t3_gap", bus.interrupt_signal_out, 0);
    step();
    check_eq("t3_btn_irq", bus.interrupt_signal_out, 1);
    check_eq("t3_btn_cause", bus.int_cause_out, 11);
    check_eq("t3_btn_src", bus.int_source_out, 0);
    bus.button_in = 4'b0000;
    finish_handler();

    // Stall holds off a pending timer.
    bus.stall_signal_in = 1'b1;
    pulse_timer();
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("t4_stalled", bus.interrupt_signal_out, 0);
    end
    bus.stall_signal_in = 1'b0;
    step();
    check_eq("t4_irq", bus.interrupt_signal_out, 1);
    finish_handler();

    // Masked switch stays pending until enabled.
    bus.csr_mie_meie_in = 1'b0;
    bus.csr_mbutton_ctrl_in = 4'b0000;
    bus.switch_in = 4'b0010;
    run(4);
    check_eq("t5_pend", bus.pending_out[5], 1);
    check_eq("t5_idle", bus.in_handler_out, 0);
    bus.csr_mie_meie_in = 1'b1;
    bus.csr_mswitch_ctrl_in = 4'b0010;
    wait_irq("t5_lat", 4, 1);
    check_eq("t5_src", bus.int_source_out, 5);
    finish_handler();

    // Reset while in the handler.
    bus.csr_mswitch_ctrl_in = 4'b0000;
    pulse_timer();
    run(2);
    rst_n_in = 1'b0;
    step();
    check_eq("t6_irq", bus.interrupt_signal_out, 0);
    check_eq("t6_redir", bus.pc_redirect_out, 0);
    check_eq("t6_target", bus.pc_target_out, 0);
    check_eq("t6_cause", bus.int_cause_out, 0);
    check_eq("t6_inh", bus.in_handler_out, 0);
    check_eq("t6_pend", bus.pending_out, 0);
    rst_n_in = 1'b1;
    bus.return_interrupt_signal_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("t6_noredir", bus.pc_redirect_out, 0);
    end
    bus.return_interrupt_signal_in = 1'b0;

    // Random traffic.
    bus.csr_mie_mtie_in = 1'b1;
    bus.csr_mie_meie_in = 1'b1;
    bus.csr_mbutton_ctrl_in = 4'hf;
    bus.csr_mswitch_ctrl_in = 4'hf;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0) bus.button_in = 4'($urandom);
      if ($urandom_range(0, 19) == 0) bus.switch_in = bus.switch_in ^ 4'(1 << $urandom_range(0, 3));
      bus.timer_interrupt_trigger_in = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 49) == 0) begin
        bus.csr_mie_mtie_in = ($urandom_range(0, 3) != 0);
        bus.csr_mie_meie_in = ($urandom_range(0, 3) != 0);
        bus.csr_mbutton_ctrl_in = 4'($urandom);
        bus.csr_mswitch_ctrl_in = 4'($urandom);
      end
      bus.stall_signal_in = ($urandom_range(0, 3) == 0);
      bus.return_interrupt_signal_in = ($urandom_range(0, 2) == 0);
      bus.csr_mepc_in = {$urandom, $urandom};
      rst_n_in = ($urandom_range(0, 399) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
